// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and oversampling sample points.
package uart_pkg;

  // Receiver states, 3-bit encoding shared by all UART blocks.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Sample-counter values (16x oversampling) at which the line is evaluated.
  localparam logic [3:0] SMP_MID = 4'd7;   // middle of the start bit
  localparam logic [3:0] SMP_END = 4'd15;  // one full bit period later

  // Index of the last data bit in an 8N1 frame.
  localparam logic [2:0] LAST_BIT = 3'd7;

  // True on the oversampling tick that lands on a given sample point.
  function automatic logic at_sample(input logic       tick,
                                     input logic [3:0] cnt,
                                     input logic [3:0] point);
    return tick && (cnt == point);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: counts 0..OVS_DIV-1, ticks on the last count.
module uart_baud_tick #(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Free-running divider; clr realigns it to the start of a frame.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling and a single-entry output holding stage.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | line idle, waiting for rxs to fall
//   START       | checking mid start bit; high there means a glitch
//   DATA        | sampling 8 data bits, one per 16 ticks, LSB first
//   STOP        | sampling the stop bit; low means framing error
//   WAIT_HIGH   | after a framing error, waiting for the line to go idle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       data_in,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  uart_state_e r_state, w_state_nxt;

  logic       r_sync1, r_rxs;
  logic [3:0] r_sample;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_frame_err, r_overrun;

  logic w_tick;
  logic w_clr_tick, w_clr_sample, w_clr_bits;
  logic w_shift, w_done, w_ferr;

  uart_baud_tick #(.OVS_DIV(OVS_DIV)) u_baud_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .clr    (w_clr_tick),
    .tick   (w_tick)
  );

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= data_in;
      r_rxs   <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_clr_tick   = 1'b0;
    w_clr_sample = 1'b0;
    w_clr_bits   = 1'b0;
    w_shift      = 1'b0;
    w_done       = 1'b0;
    w_ferr       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt  = ST_START;
          w_clr_tick   = 1'b1;
          w_clr_sample = 1'b1;
          w_clr_bits   = 1'b1;
        end
      end
      ST_START: begin
        if (at_sample(w_tick, r_sample, SMP_MID)) begin
          if (r_rxs) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt  = ST_DATA;
            w_clr_sample = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (at_sample(w_tick, r_sample, SMP_END)) begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (at_sample(w_tick, r_sample, SMP_END)) begin
          if (r_rxs) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_HIGH;
            w_ferr      = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (r_rxs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sample counter: advances once per tick; clearing wins over the tick.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_sample <= 4'd0;
    end else if (w_clr_sample) begin
      r_sample <= 4'd0;
    end else if (w_tick) begin
      r_sample <= r_sample + 4'd1;
    end
  end

  // Bit counter and shift register: bits enter at the MSB, so the first
  // (LSB) bit ends up in bit 0 after eight shifts.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (w_clr_bits) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift) begin
        r_shift <= {r_rxs, r_shift[7:1]};
      end
    end
  end

  // Holding stage: a completed byte is dropped only when the old one is
  // still pending and not being taken in this same cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_done) begin
        if (r_rx_valid && !rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl at OVS_DIV=4 (64 clocks per bit).
module tb_uart_rx_ctrl;

  localparam int OVS = 4;
  localparam int BIT = 16 * OVS;
  localparam int LAT = 152 * OVS + 3;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_ctrl #(.OVS_DIV(OVS)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .data_in   (data_in),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation of outputs on the falling edge.
  int         rise_cnt = 0, fall_cnt = 0, last_rise_cyc = 0, last_valid_len = 0;
  logic [7:0] last_rise_data = 8'h00;
  int         ferr_cnt = 0, last_ferr_cyc = 0, ovr_cnt = 0, last_ovr_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] consumed_q[$];

  always @(negedge clk_in) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      last_rise_cyc  = cyc;
      last_rise_data = rx_data;
    end
    if (!rx_valid && prev_valid) begin
      fall_cnt++;
      last_valid_len = cyc - last_rise_cyc;
    end
    if (rx_valid && rx_ready) consumed_q.push_back(rx_data);
    if (frame_err) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (overrun) begin
      ovr_cnt++;
      last_ovr_cyc = cyc;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Inputs change 1 time unit after a rising edge; tasks keep that phase.
  task automatic drive_bits(input logic v, input int n);
    data_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int fall_cyc);
    fall_cyc = cyc;
    drive_bits(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bits(b[i], BIT);
    drive_bits(stop_v, BIT);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    n_cmp++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0/0", busy, rx_valid); end
  endtask

  task automatic test_basic;
    int fc, r0, f0;
    rx_ready = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, fc);
    drive_bits(1'b1, 20);
    n_cmp++; if (rise_cnt - r0 !== 1) begin n_bad++; $display("FAIL basic_count: got %0d frames expected 1", rise_cnt - r0); end
    n_cmp++; if (last_rise_cyc - fc !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d expected %0d", last_rise_cyc - fc, LAT); end
    n_cmp++; if (last_rise_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h expected a5", last_rise_data); end
    n_cmp++; if (last_valid_len !== 1) begin n_bad++; $display("FAIL basic_valid_len: got %0d expected 1", last_valid_len); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int r0, f0;
    r0 = rise_cnt; f0 = ferr_cnt;
    drive_bits(1'b0, 20);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_during: got %b expected 1", busy); end
    drive_bits(1'b1, 200);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_after: got %b expected 0", busy); end
    n_cmp++; if (rise_cnt - r0 !== 0 || ferr_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_outputs: got frames=%0d ferr=%0d expected 0/0", rise_cnt - r0, ferr_cnt - f0); end
  endtask

  task automatic test_frame_err;
    int fc, r0, f0;
    rx_ready = 1'b1;
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, fc);
    drive_bits(1'b0, 200);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    n_cmp++; if (last_ferr_cyc - fc !== LAT) begin n_bad++; $display("FAIL ferr_timing: got %0d expected %0d", last_ferr_cyc - fc, LAT); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_low: got %b expected 1", busy); end
    n_cmp++; if (rise_cnt - r0 !== 0) begin n_bad++; $display("FAIL ferr_no_valid: got %0d frames expected 0", rise_cnt - r0); end
    drive_bits(1'b1, 4);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
    drive_bits(1'b1, 10);
    r0 = rise_cnt;
    send_frame(8'h55, 1'b1, fc);
    drive_bits(1'b1, 20);
    n_cmp++; if (rise_cnt - r0 !== 1 || last_rise_data !== 8'h55) begin n_bad++; $display("FAIL ferr_next_frame: got frames=%0d data=%h expected 1/55", rise_cnt - r0, last_rise_data); end
  endtask

  task automatic test_overrun;
    int fc1, fc2, o0, q0;
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, fc1);
    send_frame(8'h22, 1'b1, fc2);
    drive_bits(1'b1, 10);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_kept: got valid=%b data=%h expected 1/11", rx_valid, rx_data); end
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cnt - o0); end
    n_cmp++; if (last_ovr_cyc - fc2 !== LAT) begin n_bad++; $display("FAIL ovr_timing: got %0d expected %0d", last_ovr_cyc - fc2, LAT); end
    q0 = consumed_q.size();
    rx_ready = 1'b1;
    drive_bits(1'b1, 3);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consume_valid: got %b expected 0", rx_valid); end
    n_cmp++; if (consumed_q.size() - q0 !== 1 || consumed_q[$] !== 8'h11) begin n_bad++; $display("FAIL ovr_consume_data: got n=%0d last=%h expected 1/11", consumed_q.size() - q0, consumed_q[$]); end
    rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int fc, fl0, o0, q0;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, fc);
    drive_bits(1'b1, 10);
    fl0 = fall_cnt; o0 = ovr_cnt; q0 = consumed_q.size();
    fork
      send_frame(8'h22, 1'b1, fc);
      begin
        repeat (LAT - 1) @(posedge clk_in);
        #1 rx_ready = 1'b1;
        @(posedge clk_in);
        #1 rx_ready = 1'b0;
      end
    join
    drive_bits(1'b1, 10);
    n_cmp++; if (fall_cnt !== fl0) begin n_bad++; $display("FAIL b2b_valid_held: got %0d drops expected 0", fall_cnt - fl0); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin n_bad++; $display("FAIL b2b_data: got valid=%b data=%h expected 1/22", rx_valid, rx_data); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL b2b_overrun: got %0d expected 0", ovr_cnt - o0); end
    n_cmp++; if (consumed_q.size() - q0 !== 1 || consumed_q[$] !== 8'h11) begin n_bad++; $display("FAIL b2b_consumed: got n=%0d last=%h expected 1/11", consumed_q.size() - q0, consumed_q[$]); end
    rx_ready = 1'b1;
    drive_bits(1'b1, 3);
    n_cmp++; if (rx_valid !== 1'b0 || consumed_q[$] !== 8'h22) begin n_bad++; $display("FAIL b2b_drain: got valid=%b last=%h expected 0/22", rx_valid, consumed_q[$]); end
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int fc, r0;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    fork
      send_frame(8'hFF, 1'b1, fc);
      begin
        repeat (5 * BIT + 32) @(posedge clk_in);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin n_bad++; $display("FAIL rstmid_outputs: got valid=%b data=%h ferr=%b ovr=%b busy=%b expected all 0", rx_valid, rx_data, frame_err, overrun, busy); end
        repeat (3) @(posedge clk_in);
        #3 reset = 1'b1;
      end
    join
    drive_bits(1'b1, 20);
    n_cmp++; if (rise_cnt - r0 !== 0) begin n_bad++; $display("FAIL rstmid_partial: got %0d frames expected 0", rise_cnt - r0); end
    send_frame(8'h81, 1'b1, fc);
    drive_bits(1'b1, 20);
    n_cmp++; if (rise_cnt - r0 !== 1 || last_rise_data !== 8'h81 || last_rise_cyc - fc !== LAT) begin n_bad++; $display("FAIL rstmid_next: got frames=%0d data=%h lat=%0d expected 1/81/%0d", rise_cnt - r0, last_rise_data, last_rise_cyc - fc, LAT); end
    rx_ready = 1'b0;
  endtask

  // Random frames, random stop bits and consumer readiness, checked against
  // a one-slot mailbox model evaluated per frame.
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic       m_valid;
    logic [7:0] m_data, b;
    logic       r, good;
    int         exp_ferr, exp_ovr, f0, o0, fc;
    m_valid = 1'b0; m_data = 8'h00; exp_ferr = 0; exp_ovr = 0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    consumed_q.delete();
    for (int k = 0; k < 14; k++) begin
      r    = 1'($urandom_range(0, 1));
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      rx_ready = r;
      if (r && m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
      send_frame(b, good, fc);
      if (good) begin
        if (m_valid) exp_ovr++;
        else begin m_valid = 1'b1; m_data = b; end
        if (r && m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
      end else begin
        exp_ferr++;
        drive_bits(1'b0, $urandom_range(0, 100));
      end
      drive_bits(1'b1, $urandom_range(4, 30));
    end
    rx_ready = 1'b1;
    drive_bits(1'b1, 4);
    if (m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
    rx_ready = 1'b0;
    n_cmp++; if (consumed_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d bytes expected %0d", consumed_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < consumed_q.size(); i++) begin
      n_cmp++; if (consumed_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, consumed_q[i], exp_q[i]); end
    end
    n_cmp++; if (ferr_cnt - f0 !== exp_ferr) begin n_bad++; $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    n_cmp++; if (ovr_cnt - o0 !== exp_ovr) begin n_bad++; $display("FAIL rand_overrun: got %0d expected %0d", ovr_cnt - o0, exp_ovr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
